// File: rtl/iniciador_bus_rtc.sv
// ============================================================================
// Module      : iniciador_bus_rtc
// Description : Bus initiator for the RTC register port. Issues one read or
//               write transaction (cs / strobes / dir / dato), waits for the
//               completion byte, captures read data and releases the bus.
//               Optional macro ADDR_CHECK_EN rejects unmapped addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iniciador_bus_rtc #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int RD_SETTLE      = 3,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] datoin,
    output logic       cs,
    output logic       writestrobe,
    output logic       readstrobe,
    output logic [7:0] dir,
    output logic [7:0] dato,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rdata
);

    localparam logic [16:0] c_timeout_lim = 17'(TIMEOUT_CYCLES);
    localparam logic [16:0] c_settle_lim  = 17'(RD_SETTLE);
    localparam logic [16:0] c_release_lim = 17'(RELEASE_CYCLES);
    localparam logic [7:0]  c_ack_byte    = 8'd1;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SETUP       = 4'd1,
        S_STROBE      = 4'd2,
        S_WAIT_ACK    = 4'd3,
        S_READ_SETTLE = 4'd4,
        S_CAPTURE     = 4'd5,
        S_RELEASE     = 4'd6,
        S_DONE        = 4'd7,
        S_REJECT      = 4'd8
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [15:0] r_cnt_q,   w_cnt_d;
    logic        r_rw_q,    w_rw_d;
    logic [7:0]  r_addr_q,  w_addr_d;
    logic [7:0]  r_wdata_q, w_wdata_d;
    logic        r_err_q,   w_err_d;
    logic [7:0]  r_rdata_q, w_rdata_d;

    logic        r_cs_q,    w_cs_d;
    logic        r_wstb_q,  w_wstb_d;
    logic        r_rstb_q,  w_rstb_d;
    logic [7:0]  r_dir_q,   w_dir_d;
    logic [7:0]  r_dato_q,  w_dato_d;
    logic        r_busy_q,  w_busy_d;
    logic        r_done_q,  w_done_d;
    logic        r_error_q, w_error_d;

    logic [16:0] w_cnt_inc;
    assign w_cnt_inc = {1'b0, r_cnt_q} + 17'd1;

`ifdef ADDR_CHECK_EN
    logic w_addr_ok;
    assign w_addr_ok = (addr == 8'd10) || (addr == 8'd11) ||
                       ((addr >= 8'd33) && (addr <= 8'd38)) ||
                       ((addr >= 8'd65) && (addr <= 8'd67));
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_rw_d    = r_rw_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_err_d   = r_err_q;
        w_rdata_d = r_rdata_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_rw_d    = rw;
                    w_addr_d  = addr;
                    w_wdata_d = wdata;
                    w_cnt_d   = 16'd0;
`ifdef ADDR_CHECK_EN
                    w_err_d   = !w_addr_ok;
                    w_state_d = w_addr_ok ? S_SETUP : S_REJECT;
`else
                    w_err_d   = 1'b0;
                    w_state_d = S_SETUP;
`endif
                end
            end
            S_SETUP:  w_state_d = S_STROBE;
            S_STROBE: begin
                w_cnt_d   = 16'd0;
                w_state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Ack is tested before the limit so a same-cycle ack wins.
                if (datoin == c_ack_byte) begin
                    w_cnt_d   = 16'd0;
                    w_state_d = r_rw_q ? S_READ_SETTLE : S_RELEASE;
                end else if (w_cnt_inc == c_timeout_lim) begin
                    w_cnt_d   = 16'd0;
                    w_err_d   = 1'b1;
                    w_state_d = S_RELEASE;
                end else begin
                    w_cnt_d = w_cnt_inc[15:0];
                end
            end
            S_READ_SETTLE: begin
                if (w_cnt_inc == c_settle_lim) begin
                    w_cnt_d   = 16'd0;
                    w_state_d = S_CAPTURE;
                end else begin
                    w_cnt_d = w_cnt_inc[15:0];
                end
            end
            S_CAPTURE: begin
                w_rdata_d = datoin;
                w_cnt_d   = 16'd0;
                w_state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_cnt_inc == c_release_lim) begin
                    w_cnt_d   = 16'd0;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = w_cnt_inc[15:0];
                end
            end
            S_DONE:   w_state_d = S_IDLE;
            S_REJECT: w_state_d = S_DONE;
            default:  w_state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step.
        w_cs_d    = (w_state_d == S_SETUP)    || (w_state_d == S_STROBE) ||
                    (w_state_d == S_WAIT_ACK) || (w_state_d == S_READ_SETTLE) ||
                    (w_state_d == S_CAPTURE);
        w_wstb_d  = (w_state_d == S_STROBE) && !w_rw_d;
        w_rstb_d  = (w_state_d == S_STROBE) &&  w_rw_d;
        w_dir_d   = w_cs_d ? w_addr_d  : 8'd0;
        w_dato_d  = w_cs_d ? w_wdata_d : 8'd0;
        w_busy_d  = (w_state_d != S_IDLE) && (w_state_d != S_DONE);
        w_done_d  = (w_state_d == S_DONE);
        w_error_d = (w_state_d == S_DONE) && w_err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 16'd0;
            r_rw_q    <= 1'b0;
            r_addr_q  <= 8'd0;
            r_wdata_q <= 8'd0;
            r_err_q   <= 1'b0;
            r_rdata_q <= 8'd0;
            r_cs_q    <= 1'b0;
            r_wstb_q  <= 1'b0;
            r_rstb_q  <= 1'b0;
            r_dir_q   <= 8'd0;
            r_dato_q  <= 8'd0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_rw_q    <= w_rw_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_err_q   <= w_err_d;
            r_rdata_q <= w_rdata_d;
            r_cs_q    <= w_cs_d;
            r_wstb_q  <= w_wstb_d;
            r_rstb_q  <= w_rstb_d;
            r_dir_q   <= w_dir_d;
            r_dato_q  <= w_dato_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_error_q <= w_error_d;
        end
    end

    assign cs          = r_cs_q;
    assign writestrobe = r_wstb_q;
    assign readstrobe  = r_rstb_q;
    assign dir         = r_dir_q;
    assign dato        = r_dato_q;
    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign error       = r_error_q;
    assign rdata       = r_rdata_q;

endmodule

`default_nettype wire
